// File: rtl/sap_obi_demux_pkg.sv
// Shared types and helpers for the one-to-N OBI demultiplexer.
//   demux_state_e       : FSM states (IDLE, WAIT, ERR)
//   ERR_RDATA           : read data returned for an unmapped address
//   sap_obi_req_t       : default OBI request struct
//   sap_obi_resp_t      : default OBI response struct
//   clog2_min1()        : select-index width, never below one bit
package sap_obi_demux_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ERR
   } demux_state_e;

   localparam logic [31:0] ERR_RDATA = 32'hBADCAB1E;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } sap_obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } sap_obi_resp_t;

   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sap_obi_addr_decoder.sv
// Combinational priority address decoder.
// A slave hits when (addr & mask) == base; the lowest hitting index wins.
// With no hit, miss is raised and target falls back to the last slave,
// which is the default slave when no error responder is built in.
//   addr   : request address
//   target : selected slave index
//   miss   : no slave matched
module sap_obi_addr_decoder #(
   parameter int                         NSLAVE     = 2,
   parameter int                         SEL_W      = 1,
   parameter logic [NSLAVE-1:0][31:0]    SLAVE_BASE = '0,
   parameter logic [NSLAVE-1:0][31:0]    SLAVE_MASK = '0
) (
   input  logic [31:0]      addr,
   output logic [SEL_W-1:0] target,
   output logic             miss
);

   // Scan from the top down so the lowest matching index is the last write.
   always_comb begin
      target = SEL_W'(NSLAVE - 1);
      miss   = 1'b1;
      for (int i = NSLAVE - 1; i >= 0; i--) begin
         if ((addr & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
            target = SEL_W'(i);
            miss   = 1'b0;
         end
      end
   end

endmodule

// File: rtl/sap_obi_demux_one_to_n.sv
// Single-master OBI to N-slave demultiplexer with one transaction in flight.
// Request fields fan out to every slave; only the decoded slave sees req.
// gnt/rvalid/rdata come back combinationally from the selected slave.
//   clk_i         : clock
//   rst_i         : asynchronous active-high reset
//   master_req_i  : request from the master
//   master_resp_o : response to the master
//   slave_req_o   : per-slave requests
//   slave_resp_i  : per-slave responses
// Build option SAP_OBI_DEMUX_ERR_SLAVE_EN: unmapped addresses are granted
// internally and answered with ERR_RDATA one cycle later; otherwise they go
// to slave XBAR_NSLAVE-1.
//
// state | meaning
// IDLE  | nothing outstanding, requests are forwarded
// WAIT  | waiting for rvalid from slave sel_q; forwarding reopens on that rvalid
// ERR   | returning the error response for an unmapped access (option only)
module sap_obi_demux_one_to_n
   import sap_obi_demux_pkg::*;
#(
   parameter type                             obi_req_t   = sap_obi_req_t,
   parameter type                             obi_resp_t  = sap_obi_resp_t,
   parameter int                              XBAR_NSLAVE = 2,
   parameter logic [XBAR_NSLAVE-1:0][31:0]    SLAVE_BASE  = '0,
   parameter logic [XBAR_NSLAVE-1:0][31:0]    SLAVE_MASK  = '0
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  obi_req_t  master_req_i,
   output obi_resp_t master_resp_o,
   output obi_req_t  slave_req_o  [XBAR_NSLAVE],
   input  obi_resp_t slave_resp_i [XBAR_NSLAVE]
);

   localparam int SEL_W = clog2_min1(XBAR_NSLAVE);

   demux_state_e     state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d, target;
   logic             miss, to_err, fwd_en, gnt, rvalid;
   logic [31:0]      rdata;

   sap_obi_addr_decoder #(
      .NSLAVE     (XBAR_NSLAVE),
      .SEL_W      (SEL_W),
      .SLAVE_BASE (SLAVE_BASE),
      .SLAVE_MASK (SLAVE_MASK)
   ) u_dec (
      .addr   (master_req_i.addr),
      .target (target),
      .miss   (miss)
   );

`ifdef SAP_OBI_DEMUX_ERR_SLAVE_EN
   assign to_err = miss;
`else
   logic unused_miss;
   assign unused_miss = miss;
   assign to_err      = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      fwd_en  = 1'b0;
      rvalid  = 1'b0;
      rdata   = '0;
      gnt     = 1'b0;
      case (state_q)
         IDLE: fwd_en = 1'b1;
         WAIT: begin
            rvalid = slave_resp_i[sel_q].rvalid;
            rdata  = slave_resp_i[sel_q].rdata;
            // The completing cycle may already accept the next request.
            fwd_en = rvalid;
            if (rvalid) state_d = IDLE;
         end
`ifdef SAP_OBI_DEMUX_ERR_SLAVE_EN
         ERR: begin
            rvalid  = 1'b1;
            rdata   = ERR_RDATA;
            state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
      // Reset must silence the combinational paths too, not just the flops.
      if (rst_i) begin
         fwd_en = 1'b0;
         rvalid = 1'b0;
         rdata  = '0;
      end
      gnt = fwd_en & (to_err | slave_resp_i[target].gnt);
      if (master_req_i.req && gnt) begin
         sel_d   = target;
         state_d = to_err ? ERR : WAIT;
      end
   end

   always_comb begin
      master_resp_o        = '0;
      master_resp_o.gnt    = gnt;
      master_resp_o.rvalid = rvalid;
      master_resp_o.rdata  = rdata;
   end

   always_comb begin
      for (int i = 0; i < XBAR_NSLAVE; i++) begin
         slave_req_o[i]     = master_req_i;
         slave_req_o[i].req = master_req_i.req & fwd_en & ~to_err &
                              (target == SEL_W'(i));
      end
   end

`ifndef SYNTHESIS
   // While a transaction is pending only the selected slave may answer.
   logic spurious_rvalid;
   always_comb begin
      spurious_rvalid = 1'b0;
      for (int i = 0; i < XBAR_NSLAVE; i++) begin
         if (slave_resp_i[i].rvalid && state_q == WAIT && sel_q != SEL_W'(i))
            spurious_rvalid = 1'b1;
      end
   end

   always @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!spurious_rvalid)
            else $error("rvalid from a non-selected slave was dropped");
      end
   end
`endif

endmodule

// File: tb/tb_sap_obi_demux_one_to_n.sv
`timescale 1ns/1ps
module tb_sap_obi_demux_one_to_n;
   import sap_obi_demux_pkg::*;

   localparam int N = 2;
   localparam logic [N-1:0][31:0] BASE = {32'h0001_0000, 32'h0000_0000};
   localparam logic [N-1:0][31:0] MASK = {32'hFFFF_0000, 32'hFFFF_0000};
`ifdef SAP_OBI_DEMUX_ERR_SLAVE_EN
   localparam int MISS_TGT = -1;
`else
   localparam int MISS_TGT = N - 1;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i;
   sap_obi_req_t  mreq;
   sap_obi_resp_t mresp;
   sap_obi_req_t  sreq  [N];
   sap_obi_resp_t sresp [N];

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: whether a slave transaction is pending, who owns it,
   // and whether an error response is due this cycle.
   bit m_busy, m_err, n_busy, n_err;
   int m_owner, n_owner;

   always #10 clk_i = ~clk_i;

   sap_obi_demux_one_to_n #(
      .obi_req_t   (sap_obi_req_t),
      .obi_resp_t  (sap_obi_resp_t),
      .XBAR_NSLAVE (N),
      .SLAVE_BASE  (BASE),
      .SLAVE_MASK  (MASK)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .master_req_i  (mreq),
      .master_resp_o (mresp),
      .slave_req_o   (sreq),
      .slave_resp_i  (sresp)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int ref_target(input logic [31:0] a);
      for (int i = 0; i < N; i++)
         if ((a & MASK[i]) == BASE[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_err = 0; m_owner = 0;
   endtask

   task automatic set_m(input bit req, input logic [31:0] addr);
      mreq.req = req; mreq.addr = addr; mreq.we = 1'b0;
      mreq.be = 4'hF; mreq.wdata = 32'h0;
   endtask

   task automatic set_s(input int i, input bit gnt, input bit rv, input logic [31:0] rd);
      sresp[i].gnt = gnt; sresp[i].rvalid = rv; sresp[i].rdata = rd;
   endtask

   task automatic clr_s();
      for (int i = 0; i < N; i++) set_s(i, 1'b0, 1'b0, 32'h0);
   endtask

   // Let inputs settle, compare every output with the model, work out next state.
   task automatic eval();
      int t;
      bit rv_now, fwd, eg, erv;
      logic [31:0] erd;
      #3;
      t = ref_target(mreq.addr);
      if (t < 0) t = MISS_TGT;
      rv_now = m_busy && sresp[m_owner].rvalid;
      fwd    = !rst_i && !m_err && (!m_busy || rv_now);
      eg     = fwd && ((t < 0) ? 1'b1 : sresp[t].gnt);
      erv    = !rst_i && (m_err || rv_now);
      erd    = rst_i ? 32'h0 : m_err ? ERR_RDATA : m_busy ? sresp[m_owner].rdata : 32'h0;
      chk("gnt", mresp.gnt, eg);
      chk("rvalid", mresp.rvalid, erv);
      chk("rdata", mresp.rdata, erd);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("req%0d", i), sreq[i].req, mreq.req && fwd && (t == i));
         chk($sformatf("addr%0d", i), sreq[i].addr, mreq.addr);
         chk($sformatf("wdata%0d", i), sreq[i].wdata, mreq.wdata);
         chk($sformatf("be%0d", i), sreq[i].be, mreq.be);
         chk($sformatf("we%0d", i), sreq[i].we, mreq.we);
      end
      n_busy = m_busy; n_owner = m_owner; n_err = 0;
      if (mreq.req && eg) begin
         if (t < 0) begin n_err = 1; n_busy = 0; end
         else begin n_busy = 1; n_owner = t; end
      end else if (rv_now) begin
         n_busy = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      if (rst_i) model_reset();
      else begin m_busy = n_busy; m_err = n_err; m_owner = n_owner; end
      #1;
   endtask

   initial begin
      rst_i = 1'b1;
      model_reset();
      set_m(1'b1, 32'h0000_0010);
      set_s(0, 1'b1, 1'b0, 32'h0);
      set_s(1, 1'b1, 1'b0, 32'h0);
      eval();
      chk("rst0_gnt", mresp.gnt, 32'h0);
      chk("rst0_req0", sreq[0].req, 32'h0);
      tick();
      rst_i = 1'b0;

      // Plain read to slave 0, gnt held off one cycle.
      set_m(1'b1, 32'h0000_0010); clr_s();
      eval();
      chk("t1_req0", sreq[0].req, 32'h1);
      chk("t1_req1", sreq[1].req, 32'h0);
      chk("t1_gnt_lo", mresp.gnt, 32'h0);
      tick();
      set_s(0, 1'b1, 1'b0, 32'h0);
      eval();
      chk("t1_gnt", mresp.gnt, 32'h1);
      tick();
      set_m(1'b0, 32'h0); clr_s();
      eval(); chk("t1_wait_rv", mresp.rvalid, 32'h0); tick();
      eval(); tick();
      set_s(0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      eval();
      chk("t1_rvalid", mresp.rvalid, 32'h1);
      chk("t1_rdata", mresp.rdata, 32'hDEAD_BEEF);
      tick();

      // Second request to slave 1 blocked until slave 0 responds.
      set_m(1'b1, 32'h0000_0020); clr_s(); set_s(0, 1'b1, 1'b0, 32'h0);
      eval(); tick();
      set_m(1'b1, 32'h0001_0004); clr_s(); set_s(1, 1'b1, 1'b0, 32'h0);
      for (int k = 0; k < 4; k++) begin
         eval();
         chk("t2_blk_req1", sreq[1].req, 32'h0);
         chk("t2_blk_gnt", mresp.gnt, 32'h0);
         tick();
      end
      set_s(0, 1'b0, 1'b1, 32'hCAFE_0001);
      eval();
      chk("t2_req1", sreq[1].req, 32'h1);
      chk("t2_gnt", mresp.gnt, 32'h1);
      chk("t2_rdata", mresp.rdata, 32'hCAFE_0001);
      tick();

      // Back-to-back: now waiting on slave 1 only.
      set_m(1'b0, 32'h0); clr_s();
      set_s(0, 1'b0, 1'b0, 32'h5555_5555);
      set_s(1, 1'b0, 1'b0, 32'h1111_2222);
      eval();
      chk("t3_rv", mresp.rvalid, 32'h0);
      chk("t3_rdata_src", mresp.rdata, 32'h1111_2222);
      tick();
      set_s(1, 1'b0, 1'b1, 32'hA5A5_A5A5);
      eval();
      chk("t3_rv1", mresp.rvalid, 32'h1);
      chk("t3_rdata1", mresp.rdata, 32'hA5A5_A5A5);
      tick();

      // Complete a slave 0 transaction, then a stray slave 1 rvalid in idle.
      set_m(1'b1, 32'h0000_0030); clr_s(); set_s(0, 1'b1, 1'b0, 32'h0);
      eval(); tick();
      set_m(1'b0, 32'h0); clr_s(); set_s(0, 1'b0, 1'b1, 32'h0);
      eval(); tick();
      clr_s(); set_s(1, 1'b0, 1'b1, 32'h1234_5678);
      eval();
      chk("sp_rv", mresp.rvalid, 32'h0);
      chk("sp_rdata", mresp.rdata, 32'h0);
      tick();

      // Unmapped address.
      set_m(1'b1, 32'h8000_0000); set_s(0, 1'b1, 1'b0, 32'h0); set_s(1, 1'b1, 1'b0, 32'h0);
      eval();
      chk("miss_gnt", mresp.gnt, 32'h1);
      chk("miss_req0", sreq[0].req, 32'h0);
`ifdef SAP_OBI_DEMUX_ERR_SLAVE_EN
      chk("miss_req1", sreq[1].req, 32'h0);
      tick();
      set_m(1'b1, 32'h0000_0010); clr_s(); set_s(0, 1'b1, 1'b0, 32'h0);
      eval();
      chk("err_rv", mresp.rvalid, 32'h1);
      chk("err_rdata", mresp.rdata, 32'hBADC_AB1E);
      chk("err_gnt", mresp.gnt, 32'h0);
      chk("err_req0", sreq[0].req, 32'h0);
      tick();
`else
      chk("miss_req1", sreq[1].req, 32'h1);
      tick();
      set_m(1'b0, 32'h0); clr_s(); set_s(1, 1'b0, 1'b1, 32'h0000_0077);
      eval();
      chk("dflt_rv", mresp.rvalid, 32'h1);
      chk("dflt_rdata", mresp.rdata, 32'h0000_0077);
      tick();
`endif

      // Reset while waiting on slave 0.
      set_m(1'b1, 32'h0000_0010); clr_s(); set_s(0, 1'b1, 1'b0, 32'h0);
      eval(); tick();
      set_m(1'b1, 32'h0001_0000);
      set_s(0, 1'b1, 1'b1, 32'hFFFF_FFFF); set_s(1, 1'b1, 1'b0, 32'h0);
      #1 rst_i = 1'b1;
      model_reset();
      #1;
      chk("rst_gnt", mresp.gnt, 32'h0);
      chk("rst_rv", mresp.rvalid, 32'h0);
      chk("rst_rdata", mresp.rdata, 32'h0);
      chk("rst_req0", sreq[0].req, 32'h0);
      chk("rst_req1", sreq[1].req, 32'h0);
      #1 rst_i = 1'b0;
      set_m(1'b1, 32'h0000_0010); clr_s(); set_s(0, 1'b1, 1'b0, 32'h0);
      eval();
      chk("rr_req0", sreq[0].req, 32'h1);
      chk("rr_gnt", mresp.gnt, 32'h1);
      tick();

      // Random traffic; only the owner of a pending transaction may answer.
      for (int c = 0; c < 400; c++) begin
         int r;
         r = $urandom_range(0, 2);
         mreq.req   = 1'($urandom_range(0, 1));
         mreq.addr  = (r == 0) ? {16'h0000, 16'($urandom)} :
                      (r == 1) ? {16'h0001, 16'($urandom)} : {16'h8000, 16'($urandom)};
         mreq.we    = 1'($urandom_range(0, 1));
         mreq.be    = 4'($urandom);
         mreq.wdata = $urandom;
         for (int i = 0; i < N; i++) begin
            sresp[i].gnt    = 1'($urandom_range(0, 1));
            sresp[i].rdata  = $urandom;
            sresp[i].rvalid = m_busy ? ((i == m_owner) && ($urandom_range(0, 1) == 1))
                                     : 1'($urandom_range(0, 1));
         end
         eval();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
